imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//   Inverse of the immediate extender: takes a 32-bit constant plus an ImmSrc
//   code and produces the instruction immediate field that the extender
//   expands back to exactly that constant, or flags it unencodable.
//   Used by the on-chip program loader / self-test generator feeding the
//   single-cycle ARM core. Rotated data-processing immediates use an iterative
//   rotation search; other modes resolve in one cycle.
// PARAMETERS
//   none (field widths fixed by the ISA; constants live in imm_enc_pkg)
// PORTS
//   clk      in   1   single clock, rising edge
//   reset    in   1   synchronous, active-high
//   start    in   1   request strobe; accepted only when busy==0
//   ImmSrc   in   2   00 DP rotated imm, 01 LDR/STR offset, 10 branch, 11 rsvd
//   value    in   32  constant to encode; latched on accepted start
//   busy     out  1   encode in progress
//   done     out  1   one-cycle pulse: field/ok valid
//   ok       out  1   1 = encodable; held until next done
//   field    out  24  encoded Instr[23:0]; held until next done
// BEHAVIOUR
//   Decode rules being inverted (field = Instr[23:0]):
//     00: ExtImm = ROR({24'b0,field[7:0]}, 2*field[11:8]); field[23:12]=0
//     01: ExtImm = {20'b0,field[11:0]}; field[23:12]=0
//     10: ExtImm = {{6{field[23]}},field[23:0],2'b00}
//     11: reserved -> ok=0
//   Reset: busy=0, done=0, ok=0, field=0, state=IDLE, r=0.
//   FSM IDLE/SEARCH/DONE. DONE behaves as IDLE for start acceptance.
//   Accepted start latches value/ImmSrc:
//     ImmSrc 00 -> SEARCH, r=0; busy=1 from next cycle.
//     ImmSrc 01/10/11 -> DONE next cycle (latency 1), busy stays 0.
//   SEARCH, each cycle: cand = ROL(value, 2*r); if cand[31:8]==0 -> match,
//     field={12'b0,r[3:0],cand[7:0]}, ok=1, -> DONE. Else if r==15 -> ok=0,
//     field=0, -> DONE. Else r++. Lowest r wins (canonical encoding).
//   Latency mode 00 = r_match+2 cycles from start edge; unencodable = 17.
//   Mode 01: ok = (value[31:12]==0); field = ok ? {12'b0,value[11:0]} : 0.
//   Mode 10: ok = (value[1:0]==0) && value[31:25] all equal value[25];
//     field = ok ? value[25:2] : 0.
//   DONE: done=1 exactly one cycle, busy=0; returns to IDLE unless start.
//   start while busy: ignored, no queueing, latched value unchanged.
//   reset mid-SEARCH: IDLE next cycle, no done pulse, outputs cleared.
//   value==0 mode 00: match at r=0, field=0, ok=1.
// CONFIGURATION
//   IMM_ENC_FAST_EN defined: all 16 rotations tested in parallel in one
//     cycle (priority to lowest r); mode 00 latency 1, busy never asserts;
//     SEARCH state not built.
//   Undefined: iterative search as above (one rotation comparator, low area).
//   Ports, encodings and results identical either way; only latency differs.
// STRUCTURE
//   imm_enc_pkg: ImmSrc constants (IMM_DP, IMM_MEM, IMM_BR, IMM_RSVD),
//     state enum {IDLE,SEARCH,DONE}, ROT_W=4, IMM8_W=8.
//   Sub-module imm_rot_check: comb, in value+r, out match+imm8; instanced
//     once (iterative) or 16x via generate (FAST).
// TESTING
//   00, 0x000000FF -> done at cycle 2, ok=1, field=0x0000FF.
//   00, 0xFF000000 -> r=4, done at cycle 6, ok=1, field=0x0004FF.
//   00, 0x00000101 -> done at cycle 17, ok=1'b0, field=0; busy 1 for 16 cyc.
//   01, 0x00000FFF -> cycle 1 ok=1 field=0x000FFF; 01, 0x00001000 -> ok=0.
//   10, 0xFFFFFFF8 -> ok=1 field=0xFFFFFE; 10, 0x00000006 -> ok=0.
//   start 0x00000101 mode 00, pulse start again at r=2 (ignored), assert
//     reset at r=3 -> busy=0 next cycle, no done, ok=0, field=0.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared constants and types for the immediate encoder.
// Optional feature macro: IMM_ENC_FAST_EN (parallel rotation search).
package imm_enc_pkg;

  localparam int ROT_W  = 4;
  localparam int IMM8_W = 8;

  localparam logic [1:0] IMM_DP   = 2'b00;
  localparam logic [1:0] IMM_MEM  = 2'b01;
  localparam logic [1:0] IMM_BR   = 2'b10;
  localparam logic [1:0] IMM_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    DONE   = 2'b10
  } state_t;

  // Rotate a 32-bit word left by sh bits (0..31).
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] t;
    t = {v, v} << sh;
    return t[63:32];
  endfunction

endpackage

// File: rtl/imm_enc_rot_check.sv
// Tests one rotation amount: does ROL(value, 2*r) fit in 8 bits?
// Used by imm_encoder, once (iterative) or 16 times (IMM_ENC_FAST_EN).
module imm_rot_check
  import imm_enc_pkg::*;
(
  input  logic [31:0]       value,
  input  logic [ROT_W-1:0]  r,
  output logic              match,
  output logic [IMM8_W-1:0] imm8
);

  logic [31:0] cand_s;

  // Undo the decoder's right rotation and check the upper bits are clear.
  always_comb begin
    cand_s = rol32(value, {r, 1'b0});
    match  = (cand_s[31:IMM8_W] == 24'h000000);
    imm8   = cand_s[IMM8_W-1:0];
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: inverts the ARM immediate extender for DP rotated,
// LDR/STR offset and branch immediates.
// Macro IMM_ENC_FAST_EN: all 16 rotations checked in parallel, latency 1,
// no SEARCH state; otherwise one rotation is tried per cycle.
module imm_encoder
  import imm_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [23:0] field
);

  state_t            state_r, state_s;
  logic [ROT_W-1:0]  r_r, r_s;
  logic [31:0]       value_r, value_s;
  logic              busy_s, done_s, ok_s;
  logic [23:0]       field_s;

  // Single-cycle results computed from the live inputs at accept time.
  logic              dp_ok_s;
  logic [23:0]       dp_field_s;
  logic              direct_s;
  logic              imm_ok_s;
  logic [23:0]       imm_field_s;

  logic              match_s;
  logic [IMM8_W-1:0] imm8_s;

`ifdef IMM_ENC_FAST_EN
  logic [15:0]       match_v_s;
  logic [IMM8_W-1:0] imm8_v_s [16];

  for (genvar g = 0; g < 16; g++) begin : g_rot
    imm_rot_check u_chk (
      .value (value),
      .r     (ROT_W'(g)),
      .match (match_v_s[g]),
      .imm8  (imm8_v_s[g])
    );
  end

  // Lowest matching rotation wins so the encoding is canonical.
  always_comb begin
    dp_ok_s    = 1'b0;
    dp_field_s = 24'h000000;
    for (int i = 15; i >= 0; i--) begin
      if (match_v_s[i]) begin
        dp_ok_s    = 1'b1;
        dp_field_s = {12'h000, 4'(i), imm8_v_s[i]};
      end else begin
        dp_ok_s    = dp_ok_s;
        dp_field_s = dp_field_s;
      end
    end
    match_s  = 1'b0;
    imm8_s   = 8'h00;
    direct_s = 1'b1;
  end
`else
  imm_rot_check u_chk (
    .value (value_r),
    .r     (r_r),
    .match (match_s),
    .imm8  (imm8_s)
  );

  // Rotated immediates go through the iterative search instead.
  always_comb begin
    dp_ok_s    = 1'b0;
    dp_field_s = 24'h000000;
    direct_s   = (ImmSrc != IMM_DP);
  end
`endif

  // Single-cycle encodings for each ImmSrc mode.
  always_comb begin
    imm_ok_s    = 1'b0;
    imm_field_s = 24'h000000;
    case (ImmSrc)
      IMM_DP: begin
        imm_ok_s    = dp_ok_s;
        imm_field_s = dp_field_s;
      end
      IMM_MEM: begin
        imm_ok_s    = (value[31:12] == 20'h00000);
        imm_field_s = imm_ok_s ? {12'h000, value[11:0]} : 24'h000000;
      end
      IMM_BR: begin
        imm_ok_s    = (value[1:0] == 2'b00) && (value[31:25] == {7{value[25]}});
        imm_field_s = imm_ok_s ? value[25:2] : 24'h000000;
      end
      default: begin
        imm_ok_s    = 1'b0;
        imm_field_s = 24'h000000;
      end
    endcase
  end

  // Next-state and next-output logic for the IDLE/SEARCH/DONE controller.
  always_comb begin
    state_s = state_r;
    r_s     = r_r;
    value_s = value_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    ok_s    = ok;
    field_s = field;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          value_s = value;
          if (direct_s) begin
            state_s = DONE;
            done_s  = 1'b1;
            ok_s    = imm_ok_s;
            field_s = imm_field_s;
          end else begin
            state_s = SEARCH;
            r_s     = 4'd0;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
`ifndef IMM_ENC_FAST_EN
      SEARCH: begin
        if (match_s) begin
          state_s = DONE;
          done_s  = 1'b1;
          ok_s    = 1'b1;
          field_s = {12'h000, r_r, imm8_s};
        end else if (r_r == 4'd15) begin
          state_s = DONE;
          done_s  = 1'b1;
          ok_s    = 1'b0;
          field_s = 24'h000000;
        end else begin
          r_s    = r_r + 4'd1;
          busy_s = 1'b1;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      r_r     <= 4'd0;
      value_r <= 32'h00000000;
      busy    <= 1'b0;
      done    <= 1'b0;
      ok      <= 1'b0;
      field   <= 24'h000000;
    end else begin
      state_r <= state_s;
      r_r     <= r_s;
      value_r <= value_s;
      busy    <= busy_s;
      done    <= done_s;
      ok      <= ok_s;
      field   <= field_s;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed table, corner sequences,
// and randomized vectors against a decode-rule search model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  ImmSrc;
  logic [31:0] value;
  logic        busy, done, ok;
  logic [23:0] field;

  int checks = 0;
  int failures = 0;

  imm_encoder dut (
    .clk(clk), .reset(reset), .start(start), .ImmSrc(ImmSrc), .value(value),
    .busy(busy), .done(done), .ok(ok), .field(field)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] val;
    logic        eok;
    logic [23:0] efield;
    int          elat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Reference: search the decoder's own definitions for a field that expands to v.
  task automatic model(input logic [1:0] m, input logic [31:0] v,
                       output logic mok, output logic [23:0] mf, output int mlat);
    logic [31:0] ext;
    logic [23:0] f;
    mok = 1'b0; mf = 24'h0; mlat = 1;
    case (m)
      2'b00: begin
        mlat = 17;
        for (int r = 0; r < 16 && !mok; r++)
          for (int k = 0; k < 256 && !mok; k++)
            if (ror32(32'(k), 2 * r) == v) begin
              mok = 1'b1; mf = 24'(r * 256 + k); mlat = r + 2;
            end
      end
      2'b01: begin
        mok = (v < 32'h1000);
        mf  = mok ? v[23:0] : 24'h0;
      end
      2'b10: begin
        f   = v[25:2];
        ext = {{6{f[23]}}, f, 2'b00};
        mok = (ext == v);
        mf  = mok ? f : 24'h0;
      end
      default: begin mok = 1'b0; mf = 24'h0; end
    endcase
`ifdef IMM_ENC_FAST_EN
    mlat = 1;
`endif
  endtask

  // Issue one request (called #1 after a rising edge) and wait for done.
  task automatic run_enc(input logic [1:0] m, input logic [31:0] v,
                         output int lat, output int bcnt,
                         output logic o_ok, output logic [23:0] o_f);
    start = 1'b1; ImmSrc = m; value = v;
    lat = -1; bcnt = 0; o_ok = 1'bx; o_f = 24'hx;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = n; o_ok = ok; o_f = field;
        break;
      end
    end
  endtask

  int          lat, bcnt, mlat;
  logic        rok, mok;
  logic [23:0] rf, mf;
  logic [31:0] rv;
  logic [1:0]  rm;

  initial begin
    vecs[0]  = '{2'b00, 32'h000000FF, 1'b1, 24'h0000FF, 2};
    vecs[1]  = '{2'b00, 32'hFF000000, 1'b1, 24'h0004FF, 6};
    vecs[2]  = '{2'b00, 32'h00000101, 1'b0, 24'h000000, 17};
    vecs[3]  = '{2'b01, 32'h00000FFF, 1'b1, 24'h000FFF, 1};
    vecs[4]  = '{2'b01, 32'h00001000, 1'b0, 24'h000000, 1};
    vecs[5]  = '{2'b10, 32'hFFFFFFF8, 1'b1, 24'hFFFFFE, 1};
    vecs[6]  = '{2'b10, 32'h00000006, 1'b0, 24'h000000, 1};
    vecs[7]  = '{2'b00, 32'h00000000, 1'b1, 24'h000000, 2};
    vecs[8]  = '{2'b00, 32'hC000003F, 1'b1, 24'h0001FF, 3};
    vecs[9]  = '{2'b11, 32'h00000004, 1'b0, 24'h000000, 1};
    vecs[10] = '{2'b10, 32'h01FFFFFC, 1'b1, 24'h7FFFFF, 1};
    vecs[11] = '{2'b10, 32'h02000000, 1'b0, 24'h000000, 1};

    reset = 1'b1; start = 1'b0; ImmSrc = 2'b00; value = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_ok", 32'(ok), 32'h0);
    chk("reset_field", 32'(field), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_enc(vecs[i].mode, vecs[i].val, lat, bcnt, rok, rf);
`ifdef IMM_ENC_FAST_EN
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
`else
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].elat));
`endif
      chk($sformatf("vec%0d_ok", i), 32'(rok), 32'(vecs[i].eok));
      chk($sformatf("vec%0d_field", i), 32'(rf), 32'(vecs[i].efield));
`ifndef IMM_ENC_FAST_EN
      if (i == 2) chk("unenc_busy_cycles", 32'(bcnt), 32'd16);
`endif
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
      chk($sformatf("vec%0d_ok_held", i), 32'(ok), 32'(vecs[i].eok));
    end

`ifndef IMM_ENC_FAST_EN
    // Start while busy is ignored; the latched value keeps being searched.
    start = 1'b1; ImmSrc = 2'b00; value = 32'hFF000000;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start = (n == 2);
      if (n == 2) begin ImmSrc = 2'b01; value = 32'h000000FF; end
      if (done) begin lat = n; rok = ok; rf = field; break; end
    end
    chk("busy_start_lat", 32'(lat), 32'd6);
    chk("busy_start_ok", 32'(rok), 32'h1);
    chk("busy_start_field", 32'(rf), 32'h0004FF);
    @(posedge clk); #1;

    // Reset mid-search: outputs clear, no done pulse afterwards.
    start = 1'b1; ImmSrc = 2'b00; value = 32'h00000101;
    @(posedge clk); #1; start = 1'b0;            // r=0
    @(posedge clk); #1;                          // r=1
    @(posedge clk); #1;                          // r=2
    start = 1'b1; ImmSrc = 2'b01; value = 32'h00000055;
    @(posedge clk); #1;                          // r=3
    start = 1'b0; reset = 1'b1;
    chk("mid_busy_before_reset", 32'(busy), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_reset_busy", 32'(busy), 32'h0);
    chk("mid_reset_done", 32'(done), 32'h0);
    chk("mid_reset_ok", 32'(ok), 32'h0);
    chk("mid_reset_field", 32'(field), 32'h0);
    bcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done || busy) bcnt++;
    end
    chk("mid_reset_quiet", 32'(bcnt), 32'h0);
`endif

    // Randomized vectors against the reference model.
    for (int i = 0; i < 120; i++) begin
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rv = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
        1: rv = 32'($urandom_range(0, 8191));
        2: rv = {{6{1'b1}}, 26'($urandom)} & 32'hFFFFFFFC;
        default: rv = $urandom;
      endcase
      model(rm, rv, mok, mf, mlat);
      run_enc(rm, rv, lat, bcnt, rok, rf);
      chk($sformatf("rnd%0d_m%0d_v%h_lat", i, rm, rv), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_m%0d_v%h_ok", i, rm, rv), 32'(rok), 32'(mok));
      chk($sformatf("rnd%0d_m%0d_v%h_field", i, rm, rv), 32'(rf), 32'(mf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
